// File: rtl/bram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bram_arb_pkg
// Brief    : Shared constants and types for the two-requester BRAM port arbiter.
// Revision : 1.0
// ============================================================================
package bram_arb_pkg;

   localparam int c_addr_w      = 14;
   localparam int c_data_w      = 512;
   localparam int c_n_req       = 2;
   localparam int c_bram_rd_lat = 1;

   typedef logic [$clog2(c_n_req)-1:0] req_idx_t;

endpackage
`default_nettype wire

// File: rtl/bram_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram_resp_fifo
// Brief    : Synchronous read-response FIFO, push and pop allowed together at
//            any occupancy including full.
// Revision : 1.0
// ============================================================================
module bram_resp_fifo #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_pop,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_rdata
);
   localparam int c_ptr_w = $clog2(DEPTH);

   logic [c_ptr_w:0]  r_wr_ptr;
   logic [c_ptr_w:0]  r_rd_ptr;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_wr;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                    (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
   assign w_pop   = i_pop && !w_empty;
   // When full, a simultaneous pop frees the head slot that the push reuses.
   assign w_wr    = i_push && (!w_full || w_pop);

   assign o_valid = !w_empty;
   assign o_rdata = r_mem[r_rd_ptr[c_ptr_w-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + (c_ptr_w+1)'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + (c_ptr_w+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_wdata;
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(i_push && w_full && !w_pop));

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Brief    : Round-robin sharing of one BRAM port between two requesters with
//            credit-gated per-requester read-response buffers.
// Revision : 1.0
// ============================================================================
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_W     = c_addr_w,
   parameter int DATA_W     = c_data_w,
   parameter int RESP_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [c_n_req-1:0]        req_valid,
   output logic [c_n_req-1:0]        req_ready,
   input  logic [c_n_req-1:0]        req_we,
   input  logic [c_n_req*ADDR_W-1:0] req_addr,
   input  logic [c_n_req*DATA_W-1:0] req_wdata,
   output logic [c_n_req-1:0]        resp_valid,
   input  logic [c_n_req-1:0]        resp_ready,
   output logic [c_n_req*DATA_W-1:0] resp_rdata,
   output logic                      bram_en,
   output logic                      bram_we,
   output logic [ADDR_W-1:0]         bram_addr,
   output logic [DATA_W-1:0]         bram_di,
   input  logic [DATA_W-1:0]         bram_do
);
   localparam int c_cred_w = $clog2(RESP_DEPTH + 1);

   logic [c_n_req-1:0]   w_has_credit;
   logic [c_n_req-1:0]   w_elig;
   logic [c_n_req-1:0]   w_grant;
   logic [c_n_req-1:0]   w_push;
   logic                 w_any;
   req_idx_t             w_winner;
   req_idx_t             r_rr_ptr;
   logic [c_bram_rd_lat:0] r_pipe_v;
   req_idx_t             r_pipe_tag [c_bram_rd_lat+1];

   always_comb begin
      w_elig   = req_valid & (req_we | w_has_credit);
      w_winner = '0;
      w_grant  = '0;
      if (w_elig == '1)
         w_winner = r_rr_ptr;
      else if (w_elig[1])
         w_winner = req_idx_t'(1);
      // Grants are held off while reset is asserted so req_ready reads 0.
      if (!rst && (w_elig != '0))
         w_grant[w_winner] = 1'b1;
   end

   assign req_ready = w_grant;
   assign w_any     = |w_grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr  <= '0;
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
         bram_addr <= '0;
         bram_di   <= '0;
      end else if (w_any) begin
         r_rr_ptr  <= ~w_winner;
         bram_en   <= 1'b1;
         bram_we   <= req_we[w_winner];
         bram_addr <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
         bram_di   <= req_wdata[int'(w_winner)*DATA_W +: DATA_W];
      end else begin
         bram_en   <= 1'b0;
         bram_we   <= 1'b0;
      end
   end

   // Stage 0 aligns with the issue cycle; the last stage aligns with bram_do.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipe_v <= '0;
         for (int k = 0; k <= c_bram_rd_lat; k++)
            r_pipe_tag[k] <= '0;
      end else begin
         r_pipe_v[0]   <= w_any && !req_we[w_winner];
         r_pipe_tag[0] <= w_winner;
         for (int k = 1; k <= c_bram_rd_lat; k++) begin
            r_pipe_v[k]   <= r_pipe_v[k-1];
            r_pipe_tag[k] <= r_pipe_tag[k-1];
         end
      end
   end

   for (genvar i = 0; i < c_n_req; i++) begin : g_req
      logic [c_cred_w-1:0] r_credit;
      logic                w_rd_gnt;
      logic                w_pop;

      assign w_rd_gnt        = w_grant[i] && !req_we[i];
      assign w_pop           = resp_valid[i] && resp_ready[i];
      assign w_has_credit[i] = (r_credit != '0);
      assign w_push[i]       = r_pipe_v[c_bram_rd_lat] &&
                               (r_pipe_tag[c_bram_rd_lat] == req_idx_t'(i));

      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            r_credit <= c_cred_w'(RESP_DEPTH);
         else if (w_rd_gnt && !w_pop)
            r_credit <= r_credit - c_cred_w'(1);
         else if (!w_rd_gnt && w_pop)
            r_credit <= r_credit + c_cred_w'(1);
      end

      bram_resp_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (RESP_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .i_push  (w_push[i]),
         .i_wdata (bram_do),
         .i_pop   (resp_ready[i]),
         .o_valid (resp_valid[i]),
         .o_rdata (resp_rdata[i*DATA_W +: DATA_W])
      );
   end

endmodule
`default_nettype wire
